// File: rtl/zld_xc9_pkg.sv
// Shared definitions for the zero run-length decoder: FSM states and token field helpers.
package zld_xc9_pkg;

  localparam int unsigned DefaultDw = 3;

  typedef enum logic [0:0] {
    StStart = 1'b0,
    StZeros = 1'b1
  } state_e;

  // Token is DW+1 bits wide; the top bit distinguishes a run from a literal.
  function automatic int unsigned token_run_bit(int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/zld_xc9_if.sv
// Valid/back-pressure stream bundle; a transfer happens on an edge with v=1 and b=0.
interface zld_xc9_if #(
  parameter int unsigned W = 3
) ();
  logic [W-1:0] d;
  logic         v;
  logic         b;

  modport master (output d, output v, input b);
  modport slave  (input d, input v, output b);
endinterface

// File: rtl/zld_xc9_dp.sv
// Decoder datapath: output data register (literal or zero) and remaining-zeros counter.
module zld_xc9_dp #(
  parameter int unsigned DW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] tok_val,
  input  logic          ld_lit,
  input  logic          ld_zero,
  input  logic          cnt_ld,
  input  logic          cnt_dec,
  output logic [DW-1:0] out_d,
  output logic          f_cnt_eq_1,
  output logic          f_len_nz
);

  logic [DW-1:0] od_q;
  logic [DW-1:0] cnt_q;

  assign out_d      = od_q;
  assign f_cnt_eq_1 = (cnt_q == DW'(1));
  assign f_len_nz   = |tok_val;

  always_ff @(posedge clock) begin
    if (reset) begin
      od_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (ld_lit) begin
        od_q <= tok_val;
      end else if (ld_zero) begin
        od_q <= '0;
      end
      // Decrement only happens in ZEROS, which is entered with cnt >= 1.
      if (cnt_ld) begin
        cnt_q <= tok_val;
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - DW'(1);
      end
    end
  end

endmodule

// File: rtl/zld_xc9_fsm.sv
// Decoder control: START/ZEROS state, input back-pressure, output valid and datapath selects.
module zld_xc9_fsm
  import zld_xc9_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_v,
  input  logic tok_run,
  input  logic run_len_nz,
  input  logic out_b,
  input  logic f_cnt_eq_1,
  output logic in_b,
  output logic out_v,
  output logic ld_lit,
  output logic ld_zero,
  output logic cnt_ld,
  output logic cnt_dec
);

  state_e state_q, state_d;
  logic   out_v_q, out_v_d;
  logic   accept;
  logic   taken;

  // While a run is being expanded no new token may enter.
  assign in_b   = (state_q == StZeros) | (out_v_q & out_b);
  assign accept = in_v & ~in_b;
  assign taken  = out_v_q & ~out_b;
  assign out_v  = out_v_q;

  always_comb begin
    state_d = state_q;
    out_v_d = out_v_q;
    ld_lit  = 1'b0;
    ld_zero = 1'b0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      StStart: begin
        if (accept) begin
          out_v_d = 1'b1;
          if (tok_run) begin
            ld_zero = 1'b1;
            cnt_ld  = 1'b1;
            if (run_len_nz) begin
              state_d = StZeros;
            end
          end else begin
            ld_lit = 1'b1;
          end
        end else if (taken) begin
          out_v_d = 1'b0;
        end
      end
      StZeros: begin
        if (taken) begin
          out_v_d = 1'b1;
          ld_zero = 1'b1;
          cnt_dec = 1'b1;
          if (f_cnt_eq_1) begin
            state_d = StStart;
          end
        end
      end
      default: begin
        state_d = StStart;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StStart;
      out_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_v_q <= out_v_d;
    end
  end

endmodule

// File: rtl/zld_xc9.sv
// Zero run-length decoder top: expands run tokens into zeros and passes literals through.
module zld_xc9
  import zld_xc9_pkg::*;
#(
  parameter int unsigned DW = DefaultDw
) (
  input  logic   clock,
  input  logic   reset,
  zld_xc9_if.slave  i,
  zld_xc9_if.master o
);

  localparam int unsigned TW          = DW + 1;
  localparam int unsigned TokenRunBit = token_run_bit(DW);

  logic [DW-1:0] tok_val;
  logic          tok_run;
  logic          ld_lit;
  logic          ld_zero;
  logic          cnt_ld;
  logic          cnt_dec;
  logic          f_cnt_eq_1;
  logic          f_len_nz;
  logic          in_b;
  logic          out_v;
  logic [DW-1:0] out_d;

  assign tok_val = i.d[DW-1:0];
  assign tok_run = i.d[TokenRunBit];
  assign i.b     = in_b;
  assign o.v     = out_v;
  assign o.d     = out_d;

  zld_xc9_fsm u_fsm (
    .clock      (clock),
    .reset      (reset),
    .in_v       (i.v),
    .tok_run    (tok_run),
    .run_len_nz (f_len_nz),
    .out_b      (o.b),
    .f_cnt_eq_1 (f_cnt_eq_1),
    .in_b       (in_b),
    .out_v      (out_v),
    .ld_lit     (ld_lit),
    .ld_zero    (ld_zero),
    .cnt_ld     (cnt_ld),
    .cnt_dec    (cnt_dec)
  );

  zld_xc9_dp #(
    .DW (DW)
  ) u_dp (
    .clock      (clock),
    .reset      (reset),
    .tok_val    (tok_val),
    .ld_lit     (ld_lit),
    .ld_zero    (ld_zero),
    .cnt_ld     (cnt_ld),
    .cnt_dec    (cnt_dec),
    .out_d      (out_d),
    .f_cnt_eq_1 (f_cnt_eq_1),
    .f_len_nz   (f_len_nz)
  );

  if (TW != DW + 1) begin : g_bad_tw
    $error("token width must be DW+1");
  end

endmodule

// File: tb/tb_zld_xc9.sv
// Bench for zld_xc9: directed cases plus a randomized encoder->decoder loopback scoreboard.
module tb_zld_xc9;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  zld_xc9_if #(.W(4)) in_if ();
  zld_xc9_if #(.W(3)) out_if ();

  zld_xc9 #(
    .DW (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .i     (in_if),
    .o     (out_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];
  logic [3:0] tok_q[$];
  logic [2:0] vals[$];

  logic       s_ib, s_ov, s_acc, s_take;
  logic [2:0] s_od;
  int         ib_cnt, take_cnt, cyc_cnt;
  logic       prev_hold = 1'b0;
  logic [2:0] prev_od = '0;
  logic       checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference decoding: literal -> its value, run -> (length field + 1) zeros.
  function automatic void model_push(input logic [3:0] tok);
    if (tok[3]) begin
      for (int k = 0; k <= int'(tok[2:0]); k++) exp_q.push_back(3'd0);
    end else begin
      exp_q.push_back(tok[2:0]);
    end
  endfunction

  task automatic step(input logic v, input logic [3:0] d, input logic ob);
    @(negedge clock);
    reset     = 1'b0;
    in_if.v   = v;
    in_if.d   = d;
    out_if.b  = ob;
    #1;
    s_ib   = in_if.b;
    s_ov   = out_if.v;
    s_od   = out_if.d;
    s_acc  = v & ~s_ib;
    s_take = s_ov & ~ob;
    if (s_ib) ib_cnt++;
    if (s_take) take_cnt++;
    cyc_cnt++;
  endtask

  task automatic rst_cycle();
    @(negedge clock);
    reset    = 1'b1;
    in_if.v  = 1'b0;
    out_if.b = 1'b0;
    #1;
    exp_q.delete();
  endtask

  task automatic feed(input logic [3:0] tok, output int waited);
    model_push(tok);
    waited = 0;
    do begin
      step(1'b1, tok, 1'b0);
      waited++;
    end while (!s_acc && waited < 40);
    check("feed_accept", s_acc, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'($urandom), 1'b0);
  endtask

  // Scoreboard: every output transfer must match the next expected value, and a
  // stalled output must not change.
  always @(negedge clock) begin
    #2;
    if (checking && !reset) begin
      if (prev_hold) begin
        check("hold_valid", out_if.v, 1);
        check("hold_data", out_if.d, prev_od);
      end
      if (out_if.v && !out_if.b) begin
        check("out_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("out_data", out_if.d, exp_q.pop_front());
      end
      prev_hold = out_if.v & out_if.b;
      prev_od   = out_if.d;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int r;
    in_if.v  = 1'b0;
    in_if.d  = '0;
    out_if.b = 1'b0;
    ib_cnt   = 0;
    take_cnt = 0;
    cyc_cnt  = 0;

    rst_cycle();
    rst_cycle();
    checking = 1'b1;
    step(1'b0, 4'h0, 1'b0);
    check("rst_ov", s_ov, 0);
    check("rst_od", s_od, 0);
    check("rst_ib", s_ib, 0);

    // Back-to-back literals.
    ib_cnt = 0; take_cnt = 0;
    feed(4'h3, w);
    feed(4'h5, w);
    check("lit_wait", w, 1);
    check("lit_first", s_od, 3);
    feed(4'h0, w);
    idle(1);
    check("lit_last", s_od, 0);
    check("lit_takes", take_cnt, 3);
    check("lit_ib_high", ib_cnt, 0);

    // Run of 3 then literal accepted on the last zero.
    feed(4'hA, w);
    ib_cnt = 0; take_cnt = 0;
    feed(4'h7, w);
    check("run3_wait", w, 3);
    check("run3_ib_high", ib_cnt, 2);
    check("run3_take_at_accept", s_take, 1);
    check("run3_zero_at_accept", s_od, 0);
    idle(1);
    check("run3_lit", s_od, 7);
    check("run3_takes", take_cnt, 4);

    // Longest run, then shortest run.
    feed(4'hF, w);
    ib_cnt = 0;
    feed(4'h1, w);
    check("run8_wait", w, 8);
    check("run8_ib_high", ib_cnt, 7);
    idle(1);
    feed(4'h8, w);
    ib_cnt = 0;
    feed(4'h2, w);
    check("run1_wait", w, 1);
    check("run1_ib_high", ib_cnt, 0);
    idle(2);
    check("run1_drained", exp_q.size(), 0);

    // Output stall in the middle of a run of 5.
    feed(4'hC, w);
    take_cnt = 0;
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'($urandom), 1'b1);
      check("stall_ov", s_ov, 1);
      check("stall_od", s_od, 0);
      check("stall_ib", s_ib, 1);
    end
    idle(5);
    check("stall_zero_count", take_cnt, 5);
    check("stall_drained", exp_q.size(), 0);

    // Reset in the middle of a run discards the remaining zeros.
    feed(4'hF, w);
    idle(2);
    rst_cycle();
    step(1'b0, 4'h0, 1'b0);
    check("midrst_ov", s_ov, 0);
    check("midrst_ib", s_ib, 0);
    take_cnt = 0;
    feed(4'h2, w);
    check("midrst_wait", w, 1);
    idle(3);
    check("midrst_takes", take_cnt, 1);
    check("midrst_drained", exp_q.size(), 0);

    // Random loopback: behavioural encoder feeds the decoder, output must equal the source.
    n = 500;
    vals.delete();
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 9) < 6) vals.push_back(3'd0);
      else vals.push_back(3'($urandom_range(1, 7)));
    end
    for (int k = 0; k < n;) begin
      exp_q.push_back(vals[k]);
      if (vals[k] != 3'd0) begin
        tok_q.push_back({1'b0, vals[k]});
        k++;
      end else begin
        r = 1;
        while (k + r < n && r < 8 && vals[k+r] == 3'd0) begin
          exp_q.push_back(3'd0);
          r++;
        end
        if (r == 1 && $urandom_range(0, 3) == 0) tok_q.push_back(4'h0);
        else tok_q.push_back({1'b1, 3'(r - 1)});
        k += r;
      end
    end
    cyc_cnt = 0;
    while ((tok_q.size() != 0 || exp_q.size() != 0) && cyc_cnt < 8000) begin
      logic       v;
      logic [3:0] d;
      v = (tok_q.size() != 0) && ($urandom_range(0, 3) != 0);
      d = v ? tok_q[0] : 4'($urandom);
      step(v, d, ($urandom_range(0, 9) < 3));
      if (s_acc) void'(tok_q.pop_front());
    end
    idle(2);
    check("rand_tokens_left", tok_q.size(), 0);
    check("rand_outputs_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zld_xc9.md
Name: zld_xc9

Overview:
- Zero run-length decoder; the stage directly downstream of the zero run-length encoder (zle_xc9).
- Consumes the encoder's token stream and reconstructs the original data stream, one value per output transfer.
- Both sides use the stream valid/back-pressure handshake.
- A transfer occurs on any clock edge where v=1 and b=0.

Parameters:
- DW, 3, data width of the decoded output stream.
- TW, DW+1 (fixed; not overridable), token width of the input stream.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_d  in  TW  token data.
- i_v  in  1  token valid.
- i_b  out  1  token back-pressure (1 = cannot accept).
- o_d  out  DW  decoded data.
- o_v  out  1  decoded data valid.
- o_b  in  1  downstream back-pressure.

Behaviour:
- Token format:
  - i_d[TW-1]=0: literal; emit one value i_d[DW-1:0]. A literal 0 is legal and emits one zero.
  - i_d[TW-1]=1: run; emit i_d[DW-1:0]+1 zeros (1..2^DW, i.e. 1..8 at default).
- Registered outputs o_d and o_v. Internal regs: state, cnt[DW-1:0].
- Reset (sync, high) forces: state=START, o_v=0, o_d=0, cnt=0. Reset mid-run discards the remaining zeros and any held output. i_b=0 on the first cycle after reset release.
- Back-pressure: i_b is combinational.
  - START: i_b = o_v & o_b.
  - ZEROS: i_b = 1.
- "Output taken" = o_v & !o_b.
- FSM state START:
  - Token accepted (i_v & !i_b), literal: o_d<=i_d[DW-1:0], o_v<=1.
  - Token accepted, run: o_d<=0, o_v<=1, cnt<=i_d[DW-1:0]. If i_d[DW-1:0]!=0, go to ZEROS; else stay in START (single zero).
  - No accept and output taken: o_v<=0.
  - Otherwise: hold o_d, o_v.
- FSM state ZEROS (cnt = zeros still to load after the one held in o_d):
  - Output taken: o_d<=0, o_v<=1, cnt<=cnt-1. If cnt==1, go to START.
  - Otherwise: hold everything.
- Latency:
  - Token accepted at edge N → first decoded value valid after edge N (visible cycle N+1).
  - Sustained throughput is 1 value/cycle with o_b=0, including back-to-back literals and run→literal transitions.
- Run of k zeros:
  - i_b is held high for k-1 output transfers.
  - The next token is accepted in the same cycle the last zero is taken.
- Simultaneous take and accept in START: the new value replaces the taken one; o_v stays 1, with no bubble.
- o_d and o_v are held stable while o_b=1. i_d is ignored when i_v=0.
- Arithmetic: cnt is unsigned DW bits. No wrap, because the decrement never occurs at cnt=0 (ZEROS is entered only with cnt≥1).

Decomposition:
- Shared package/include zld_defs:
  - START/ZEROS state encodings.
  - TOKEN_RUN_BIT = TW-1.
  - Field macros for literal value and run length.
- Natural split, matching the encoder:
  - zld_xc9_fsm: state, i_b, o_v, select signals.
  - zld_xc9_dp: o_d mux (literal vs zero), cnt register with load/decrement, flag f_cnt_eq_1.
- Top level zld_xc9 instantiates both.

Test Plan:
- Literals, o_b=0: tokens 0x3, 0x5, 0x0 back-to-back → o_d 3, 5, 0 on consecutive cycles; i_b never high.
- Run, o_b=0: token 0xA (run of 3) then literal 0x7 → o_d 0, 0, 0, 7 consecutive; i_b high exactly 2 cycles; 0x7 accepted on the cycle the third zero is taken.
- Max and min run: token 0xF → 8 zeros; token 0x8 → 1 zero, no ZEROS entry; next literal accepted without stall.
- Back-pressure: during run 0xC (5 zeros), o_b=1 for 3 cycles after the 2nd zero → o_d/o_v frozen, i_b=1; total zeros still exactly 5.
- Reset mid-run: token 0xF, pulse reset after 2 zeros taken → next cycle o_v=0, i_b=0; following literal 0x2 → single output 2, no stray zeros.
- Random: encoder→decoder loopback with random 3-bit streams (≥50% zeros) and random o_b → output equals original stream exactly.
